// File: rtl/pika_sound_player.sv
// rtl/pika_sound_player.sv - playback sequencer walking the pika_sound ROM at the sample rate
module pika_sound_player #(
  parameter int CLK_HZ    = 50000000,
  parameter int SAMPLE_HZ = 16000,
  parameter int DIV       = CLK_HZ / SAMPLE_HZ,
  parameter int LENGTH    = 11930
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        play,
  input  logic        stop,
  output logic [16:0] pika_add,
  output logic        pika_enable,
  input  logic [16:0] pika_content,
  output logic [16:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DIV - 1);
  localparam logic [16:0]   LAST_ADDR  = 17'(LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    HOLD,
    WAIT
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [16:0]   addr;
  logic [CW-1:0] count;
  logic          tick;
  logic          start;
  logic          abort;

  assign tick  = (count == LAST_COUNT);
  // stop has priority over play, and only aborts an active playback
  assign abort = busy && stop;
  assign start = play && !stop;

  // state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state logic and state-decoded ROM/codec outputs
  always_comb begin
    next_state   = state;
    busy         = (state != IDLE);
    pika_enable  = (state == FETCH);
    sample_valid = (state == HOLD);
    pika_add     = (state == IDLE) ? 17'd0 : addr;
    if (abort) begin
      next_state = IDLE;
    end else if (start) begin
      next_state = FETCH;
    end else begin
      case (state)
        FETCH:   next_state = CAPTURE;
        CAPTURE: next_state = HOLD;
        HOLD: begin
          if (sample_ready) begin
            next_state = (addr == LAST_ADDR) ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (tick) begin
            next_state = FETCH;
          end
        end
        default: next_state = state;
      endcase
    end
  end

  // address counter, sample-period divider, captured sample and status flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr     <= 17'd0;
      count    <= '0;
      sample   <= 17'd0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        addr   <= 17'd0;
        count  <= '0;
        sample <= 17'd0;
      end else if (start) begin
        addr     <= 17'd0;
        count    <= '0;
        sample   <= 17'd0;
        underrun <= 1'b0;
      end else if (busy) begin
        count <= tick ? '0 : count + CW'(1);
        case (state)
          CAPTURE: sample <= pika_content;
          HOLD: begin
            // a period boundary while the codec still owns the sample is lost
            if (tick) begin
              underrun <= 1'b1;
            end
            if (sample_ready) begin
              if (addr == LAST_ADDR) begin
                done   <= 1'b1;
                addr   <= 17'd0;
                count  <= '0;
                sample <= 17'd0;
              end else begin
                addr <= addr + 17'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pika_sound_player.sv
// tb/tb_pika_sound_player.sv - randomized self-checking bench for pika_sound_player
module tb_pika_sound_player;

  localparam int DIV    = 8;
  localparam int LENGTH = 4;
  localparam int N      = 160;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        play;
  logic        stop;
  logic [16:0] pika_add;
  logic        pika_enable;
  logic [16:0] pika_content;
  logic [16:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        done;
  logic        underrun;

  logic [16:0] rom [4];
  int          vectors = 0;
  int          miscompares = 0;
  logic        prev_ur = 1'b0;

  logic        rdy       [N];
  logic        exp_busy  [N];
  logic        exp_en    [N];
  logic [16:0] exp_add   [N];
  logic        exp_valid [N];
  logic [16:0] exp_smp   [N];
  logic        smp_care  [N];
  logic        exp_done  [N];
  logic        exp_ur    [N];

  always #5 Clk = ~Clk;

  pika_sound_player #(
    .CLK_HZ(80), .SAMPLE_HZ(10), .DIV(DIV), .LENGTH(LENGTH)
  ) dut (
    .Clk(Clk), .Reset(Reset), .play(play), .stop(stop),
    .pika_add(pika_add), .pika_enable(pika_enable), .pika_content(pika_content),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .done(done), .underrun(underrun)
  );

  // one clock; the registered ROM answers the cycle after enable
  task automatic step();
    logic        en_q;
    logic [16:0] add_q;
    en_q  = pika_enable;
    add_q = pika_add;
    @(posedge Clk);
    #1;
    pika_content = (en_q && add_q < 17'(LENGTH)) ? rom[add_q[1:0]] : 17'd0;
  endtask

  // timeline model: play at cycle 0, ticks at multiples of DIV, fetch the cycle after a tick
  task automatic build_model();
    int f;
    int a;
    int t;
    int ur_from;
    for (int c = 0; c < N; c++) begin
      exp_busy[c] = 0; exp_en[c] = 0; exp_add[c] = 0; exp_valid[c] = 0;
      exp_smp[c] = 0; smp_care[c] = 1; exp_done[c] = 0; exp_ur[c] = 0;
    end
    exp_ur[0] = prev_ur;
    f = 1;
    ur_from = N;
    for (int n = 0; n < LENGTH; n++) begin
      a = f + 2;
      while (a < N - 2 && !rdy[a]) a++;
      exp_en[f] = 1;
      for (int c = f; c <= a; c++) begin
        exp_busy[c] = 1;
        exp_add[c]  = 17'(n);
        if (c >= f + 2) begin
          exp_valid[c] = 1;
          exp_smp[c]   = rom[n];
          if (c % DIV == 0 && ur_from == N) ur_from = c + 1;
        end else begin
          smp_care[c] = (n == 0);
        end
      end
      if (n == LENGTH - 1) begin
        exp_done[a + 1] = 1;
        break;
      end
      t = DIV * (a / DIV + 1);
      for (int c = a + 1; c <= t && c < N; c++) begin
        exp_busy[c] = 1;
        exp_add[c]  = 17'(n + 1);
        smp_care[c] = 0;
      end
      f = t + 1;
    end
    for (int c = ur_from; c < N; c++) exp_ur[c] = 1;
  endtask

  task automatic test_reset();
    Reset = 1; play = 1; stop = 0; sample_ready = 1; pika_content = 0;
    step();
    step();
    Reset = 0; play = 0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (pika_enable !== 1'b0) begin miscompares++; $display("FAIL reset_en got %b want 0", pika_enable); end
    vectors++; if (pika_add !== 17'd0) begin miscompares++; $display("FAIL reset_add got %h want 0", pika_add); end
    vectors++; if (sample !== 17'd0) begin miscompares++; $display("FAIL reset_sample got %h want 0", sample); end
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun got %b want 0", underrun); end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  // iteration 0: ready tied high; 1: 12-cycle stall on sample 1; rest random
  task automatic test_playback();
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < N; c++) begin
        if (it == 0) rdy[c] = 1;
        else if (it == 1) rdy[c] = !(c >= 11 && c <= 22);
        else if (c >= 100) rdy[c] = 1;
        else if (it % 2 == 1) rdy[c] = ($urandom_range(0, 9) < 2);
        else rdy[c] = ($urandom_range(0, 3) != 0);
      end
      build_model();
      for (int c = 0; c < N; c++) begin
        play = (c == 0); stop = 0; sample_ready = rdy[c];
        vectors++; if (busy !== exp_busy[c]) begin miscompares++; $display("FAIL pb_busy it%0d c%0d got %b want %b", it, c, busy, exp_busy[c]); end
        vectors++; if (pika_enable !== exp_en[c]) begin miscompares++; $display("FAIL pb_en it%0d c%0d got %b want %b", it, c, pika_enable, exp_en[c]); end
        vectors++; if (pika_add !== exp_add[c]) begin miscompares++; $display("FAIL pb_add it%0d c%0d got %h want %h", it, c, pika_add, exp_add[c]); end
        vectors++; if (sample_valid !== exp_valid[c]) begin miscompares++; $display("FAIL pb_valid it%0d c%0d got %b want %b", it, c, sample_valid, exp_valid[c]); end
        vectors++; if (done !== exp_done[c]) begin miscompares++; $display("FAIL pb_done it%0d c%0d got %b want %b", it, c, done, exp_done[c]); end
        vectors++; if (underrun !== exp_ur[c]) begin miscompares++; $display("FAIL pb_underrun it%0d c%0d got %b want %b", it, c, underrun, exp_ur[c]); end
        if (smp_care[c]) begin
          vectors++; if (sample !== exp_smp[c]) begin miscompares++; $display("FAIL pb_sample it%0d c%0d got %h want %h", it, c, sample, exp_smp[c]); end
        end
        step();
      end
      play = 0;
      prev_ur = exp_ur[N-1];
    end
  endtask

  task automatic test_restart();
    int dones = 0;
    for (int c = 0; c < 48; c++) begin
      play = (c == 0 || c == 13); stop = 0; sample_ready = (c < 3 || c > 13);
      if (c == 12) begin
        vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL rs_underrun_pre got %b want 1", underrun); end
        vectors++; if (sample !== 17'h00011) begin miscompares++; $display("FAIL rs_sample_pre got %h want 00011", sample); end
      end
      if (c == 14) begin
        vectors++; if (pika_enable !== 1'b1) begin miscompares++; $display("FAIL rs_en got %b want 1", pika_enable); end
        vectors++; if (pika_add !== 17'd0) begin miscompares++; $display("FAIL rs_add got %h want 0", pika_add); end
        vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL rs_underrun got %b want 0", underrun); end
        vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL rs_valid got %b want 0", sample_valid); end
        vectors++; if (sample !== 17'd0) begin miscompares++; $display("FAIL rs_sample got %h want 0", sample); end
      end
      if (c == 22) begin
        vectors++; if (pika_enable !== 1'b1 || pika_add !== 17'd1) begin miscompares++; $display("FAIL rs_fetch1 got en=%b add=%h want en=1 add=1", pika_enable, pika_add); end
      end
      if (c == 40) begin
        vectors++; if (sample_valid !== 1'b1 || sample !== 17'h1FFFF) begin miscompares++; $display("FAIL rs_last got v=%b s=%h want v=1 s=1ffff", sample_valid, sample); end
      end
      if (c == 41) begin
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rs_done got %b want 1", done); end
      end else if (done === 1'b1) begin
        dones++;
      end
      step();
    end
    play = 0;
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL rs_extra_done got %0d want 0", dones); end
  endtask

  task automatic test_stop();
    int dones = 0;
    for (int c = 0; c < 10; c++) begin
      play = (c == 0); stop = (c == 3); sample_ready = 0;
      if (c == 3) begin
        vectors++; if (sample_valid !== 1'b1 || sample !== 17'h00011) begin miscompares++; $display("FAIL st_hold got v=%b s=%h want v=1 s=00011", sample_valid, sample); end
      end
      if (c == 4) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL st_busy got %b want 0", busy); end
        vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL st_valid got %b want 0", sample_valid); end
        vectors++; if (sample !== 17'd0) begin miscompares++; $display("FAIL st_sample got %h want 0", sample); end
      end
      if (done === 1'b1) dones++;
      step();
    end
    stop = 0; play = 0;
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL st_done got %0d want 0", dones); end
  endtask

  task automatic test_play_stop_idle();
    for (int c = 0; c < 6; c++) begin
      play = (c == 0); stop = (c == 0); sample_ready = 1;
      if (c >= 1) begin
        vectors++; if (busy !== 1'b0 || pika_enable !== 1'b0) begin miscompares++; $display("FAIL ps_idle c%0d got busy=%b en=%b want 0 0", c, busy, pika_enable); end
      end
      step();
    end
    play = 0; stop = 0;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    for (int c = 0; c < 14; c++) begin
      play = (c == 0); stop = 0; Reset = (c == 10); sample_ready = (c < 3);
      if (c == 9) begin
        vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL rm_underrun_pre got %b want 1", underrun); end
      end
      if (c == 11) begin
        vectors++; if (busy !== 1'b0 || sample_valid !== 1'b0 || sample !== 17'd0 || pika_add !== 17'd0 || underrun !== 1'b0)
          begin miscompares++; $display("FAIL rm_state got busy=%b v=%b s=%h add=%h ur=%b want all 0", busy, sample_valid, sample, pika_add, underrun); end
      end
      if (c >= 11 && done === 1'b1) dones++;
      step();
    end
    Reset = 0; play = 0;
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL rm_done got %0d want 0", dones); end
  endtask

  initial begin
    rom[0] = 17'h00011; rom[1] = 17'h00022; rom[2] = 17'h00033; rom[3] = 17'h1FFFF;
    test_reset();
    test_playback();
    test_restart();
    test_stop();
    test_play_stop_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
